// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit L1 line transactions onto a 4-beat, 64-bit physical memory burst.
// Refills are assembled beat by beat; write-backs are serialised from a latched copy of the line.
module cacheline_adaptor #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic [31:0]             address_i,
  input  logic [BEATS*BEAT_W-1:0] line_i,
  output logic [BEATS*BEAT_W-1:0] line_o,
  output logic                    resp_o,
  output logic [31:0]             address_o,
  output logic                    read_o,
  output logic                    write_o,
  output logic [BEAT_W-1:0]       burst_o,
  input  logic [BEAT_W-1:0]       burst_i,
  input  logic                    resp_i,
  output logic [31:0]             line_count
);

  localparam int LINE_W = BEATS * BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [31:0]      OFFSET_MASK = 32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [LINE_W-1:0] wr_line, wr_line_nxt;
  logic [LINE_W-1:0] line_nxt;
  logic [31:0]       addr_q, addr_nxt;
  logic [31:0]       line_count_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_line    <= '0;
      addr_q     <= '0;
      line_o     <= '0;
      line_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wr_line    <= wr_line_nxt;
      addr_q     <= addr_nxt;
      line_o     <= line_nxt;
      line_count <= line_count_nxt;
    end
  end

  // Write requests win over reads; requests seen mid-burst are simply re-sampled once back in IDLE.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    wr_line_nxt    = wr_line;
    addr_nxt       = addr_q;
    line_nxt       = line_o;
    line_count_nxt = line_count;
    case (state)
      IDLE: begin
        if (write_i) begin
          wr_line_nxt = line_i;
          addr_nxt    = address_i;
          cnt_nxt     = '0;
          state_nxt   = WR_BURST;
        end else if (read_i) begin
          addr_nxt  = address_i;
          cnt_nxt   = '0;
          state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          line_nxt[BEAT_W*cnt +: BEAT_W] = burst_i;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BEAT) begin
            state_nxt = DONE;
          end
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BEAT) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (line_count != '1) begin
          line_count_nxt = line_count + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    case (state)
      RD_BURST: begin
        read_o    = 1'b1;
        address_o = addr_q & ~OFFSET_MASK;
      end
      WR_BURST: begin
        write_o   = 1'b1;
        address_o = addr_q & ~OFFSET_MASK;
        burst_o   = wr_line[BEAT_W*cnt +: BEAT_W];
      end
      DONE:    resp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed test-plan scenarios plus randomized
// transactions, compared against a transaction-level model of line data, beat order and counts.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i;
  logic         write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;
  logic [31:0]  line_count;

  int           checks = 0;
  int           failures = 0;
  logic [255:0] expLine;
  logic [31:0]  expCount;

  cacheline_adaptor #(.BEATS(4), .BEAT_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i),
    .line_count(line_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] randLine();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One line transaction starting at an IDLE-cycle negedge. For reads, data supplies the beats
  // memory returns; for writes, data is the line the cache hands over.
  // gapMode: 0 = back-to-back strobes, 1 = random gaps, 2 = strobe pattern 1,0,0,1,1,0,1.
  task automatic applyStimulus(input bit wr, input bit rd, input bit keepRd,
                               input logic [31:0] addr, input logic [255:0] data,
                               input int gapMode);
    int   beats;
    int   cyc;
    int   gaps;
    bit   strobe;
    logic [6:0] pattern;
    pattern   = 7'b1011001;
    write_i   = wr;
    read_i    = rd;
    address_i = addr;
    line_i    = wr ? data : randLine();
    @(negedge clk);
    beats = 0;
    cyc   = 0;
    gaps  = 0;
    while (beats < 4) begin
      checkOutput("read_o_burst", 256'(read_o), 256'(!wr));
      checkOutput("write_o_burst", 256'(write_o), 256'(wr));
      checkOutput("resp_o_burst", 256'(resp_o), 256'(0));
      checkOutput("address_o_burst", 256'(address_o), 256'({addr[31:5], 5'b0}));
      if (wr) checkOutput("burst_o", 256'(burst_o), 256'(data[64*beats +: 64]));
      case (gapMode)
        0:       strobe = 1'b1;
        1:       strobe = ($urandom_range(0, 2) != 0) || (gaps >= 3);
        default: strobe = (cyc < 7) ? pattern[cyc] : 1'b1;
      endcase
      gaps    = strobe ? 0 : gaps + 1;
      resp_i  = strobe;
      burst_i = (!wr) ? data[64*beats +: 64] : {$urandom, $urandom};
      @(negedge clk);
      if (strobe) beats++;
      cyc++;
    end
    checkOutput("resp_o_done", 256'(resp_o), 256'(1));
    checkOutput("read_o_done", 256'(read_o), 256'(0));
    checkOutput("write_o_done", 256'(write_o), 256'(0));
    checkOutput("address_o_done", 256'(address_o), 256'(0));
    read_i  = keepRd;
    write_i = 1'b0;
    resp_i  = 1'($urandom_range(0, 1));
    burst_i = {$urandom, $urandom};
    if (!wr) expLine = data;
    if (expCount != 32'hFFFF_FFFF) expCount = expCount + 32'd1;
    @(negedge clk);
    checkOutput("resp_o_idle", 256'(resp_o), 256'(0));
    checkOutput("read_o_idle", 256'(read_o), 256'(0));
    checkOutput("write_o_idle", 256'(write_o), 256'(0));
    checkOutput("line_o", line_o, expLine);
    checkOutput("line_count", 256'(line_count), 256'(expCount));
    resp_i = 1'($urandom_range(0, 1));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_line_o"}, line_o, 256'(0));
    checkOutput({tag, "_resp_o"}, 256'(resp_o), 256'(0));
    checkOutput({tag, "_address_o"}, 256'(address_o), 256'(0));
    checkOutput({tag, "_read_o"}, 256'(read_o), 256'(0));
    checkOutput({tag, "_write_o"}, 256'(write_o), 256'(0));
    checkOutput({tag, "_burst_o"}, 256'(burst_o), 256'(0));
    checkOutput({tag, "_line_count"}, 256'(line_count), 256'(0));
  endtask

  initial begin
    logic [255:0] d;
    bit           wr;
    rst       = 1'b0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = '0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    expLine   = '0;
    expCount  = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;

    $display("[TB] directed read burst");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1234,
                  {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0);

    $display("[TB] directed write burst");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D,
                  {64'hD3D3_0000_3333_D3D3, 64'hD2D2_0000_2222_D2D2,
                   64'hD1D1_0000_1111_D1D1, 64'hD0D0_0000_0000_D0D0}, 0);

    $display("[TB] gapped read");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h8000_0040, randLine(), 2);

    $display("[TB] simultaneous request, read held across completion");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000, randLine(), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_2000, randLine(), 1);

    $display("[TB] reset mid-burst");
    read_i    = 1'b1;
    address_i = 32'h1234_5678;
    @(negedge clk);
    resp_i  = 1'b1;
    burst_i = {$urandom, $urandom};
    @(negedge clk);
    burst_i = {$urandom, $urandom};
    @(negedge clk);
    rst    = 1'b0;
    read_i = 1'b0;
    resp_i = 1'b0;
    #1;
    checkAllZero("midreset");
    expLine  = '0;
    expCount = '0;
    @(negedge clk);
    checkOutput("midreset_no_resp", 256'(resp_o), 256'(0));
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, randLine(), 0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 20; n++) begin
      wr = 1'($urandom_range(0, 1));
      d  = randLine();
      applyStimulus(wr, !wr || ($urandom_range(0, 3) == 0), 1'b0, $urandom, d, 1);
    end

    $display("[TB] line_count saturation");
    read_i  = 1'b0;
    write_i = 1'b0;
    force dut.line_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.line_count;
    expCount = 32'hFFFF_FFFE;
    checkOutput("line_count_preset", 256'(line_count), 256'(expCount));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0100, randLine(), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0200, randLine(), 1);
    checkOutput("line_count_saturated", 256'(line_count), 256'(32'hFFFF_FFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts 256-bit cacheline transactions from the L1 side (the instruction cache miss path, or the arbiter in front of both L1 caches) into 4-beat, 64-bit bursts on physical memory. It sits directly downstream of the instruction cache controller:
- that controller's line-read request drives `read_i`;
- `resp_o` drives its memory-response input.

The block assembles refill lines beat by beat, serialises write-back lines, and produces a single-cycle completion pulse per line.

## Interface
Parameters:
- `BEATS`, 4, bursts per line; fixed to 4, and other values are unsupported.
- `BEAT_W`, 64, bits per burst beat.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `read_i`  in  1  line read request from cache; held until `resp_o`.
- `write_i`  in  1  line write request from cache; held until `resp_o`.
- `address_i`  in  32  line address from cache.
- `line_i`  in  256  write-back line data.
- `line_o`  out  256  assembled refill line.
- `resp_o`  out  1  one-cycle completion pulse to cache.
- `address_o`  out  32  burst address to memory; bits [4:0] always 0.
- `read_o`  out  1  burst read request to memory.
- `write_o`  out  1  burst write request to memory.
- `burst_o`  out  64  write beat data.
- `burst_i`  in  64  read beat data.
- `resp_i`  in  1  memory beat strobe: one beat transferred per cycle it is high.
- `line_count`  out  32  completed line transactions, saturating.

## Operation
- Moore FSM with states IDLE, RD_BURST, WR_BURST, DONE; 2-bit beat counter `cnt`.
- IDLE:
  - if `write_i`: latch `line_i` and `address_i`, set `cnt`=0, go to WR_BURST.
  - else if `read_i`: latch `address_i`, set `cnt`=0, go to RD_BURST.
  - `write_i` has priority when both are high.
- RD_BURST:
  - `read_o`=1.
  - On each cycle with `resp_i`=1, capture `burst_i` into `line_o[64*cnt +: 64]` and increment `cnt`.
  - The beat with `cnt`==3 moves to DONE.
- WR_BURST:
  - `write_o`=1; `burst_o` = latched `line[64*cnt +: 64]`.
  - Each `resp_i`=1 retires one beat and increments `cnt`.
  - The beat with `cnt`==3 moves to DONE.
- DONE:
  - `resp_o`=1 for exactly this cycle; increment `line_count` unless it is 0xFFFF_FFFF.
  - Always return to IDLE next cycle.
- `address_o` = {latched `address_i`[31:5], 5'b0} in RD_BURST/WR_BURST, and 0 otherwise.
- `line_o` holds its last assembled value until the next read overwrites it, beat by beat. Write transactions never alter `line_o`.
- `resp_i` is ignored in IDLE and DONE.
- `read_o` and `write_o` are never high together.
- Requests arriving during a burst are not queued. The cache holds its request, and the request is re-sampled in IDLE.

## Timing
- Reset values, while `rst`=0 and asynchronously on assertion:
  - state IDLE; `cnt`=0;
  - `line_o`=0, `resp_o`=0, `address_o`=0, `read_o`=0, `write_o`=0, `burst_o`=0, `line_count`=0.
- Reset mid-burst drops the transaction with no `resp_o`.
- Request sampled in IDLE at edge T: `read_o`/`write_o` high from T+1.
- With four back-to-back `resp_i` cycles at T+1..T+4: DONE, and therefore `resp_o`, at T+5. Minimum line latency is 5 cycles.
- Gaps in `resp_i` stretch the burst one cycle per idle cycle; there is no timeout.
- After DONE the FSM spends at least one cycle in IDLE. A request still high in the IDLE cycle right after DONE starts a new transaction, so the cache must drop its request on seeing `resp_o`.
- `burst_o` changes only on the edge following an accepted beat. It is stable while `resp_i`=0.

## Test plan
- **Read burst:** `read_i`=1, `address_i`=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive `resp_i` cycles.
  - `address_o`=0x0000_1220.
  - `resp_o` pulses once at T+5.
  - `line_o`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write burst:** `write_i`=1, `line_i`={D3,D2,D1,D0}, `resp_i` held high 4 cycles.
  - `burst_o` = D0, D1, D2, D3 in order; `write_o`=1 for 4 cycles; `resp_o` at T+5.
  - `line_o` unchanged.
- **Gapped read:** `resp_i` pattern 1,0,0,1,1,0,1 → all 4 beats captured correctly; `resp_o` exactly one cycle after the 4th strobe.
- **Simultaneous request:** `read_i` and `write_i` both high in IDLE → write burst first (`read_o`=0 throughout).
  - After `resp_o`, with `read_i` still held, the read burst starts.
- **Reset mid-burst:** `rst`=0 after 2 read beats → all outputs 0 immediately; no `resp_o`; `line_count`=0.
  - The next read completes normally.
- **Saturation:** force `line_count`=0xFFFF_FFFE, run 2 reads → `line_count` stays at 0xFFFF_FFFF.
